// File: rtl/updown_led_counter.sv
// Button-driven up/down LED counter: per-button synchroniser, debouncer and rising-edge pulse,
// then a wrap/saturate counter. Define AUTO_REPEAT_EN to build hold-to-repeat timers on add/sub.

module updown_led_counter_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit REPEAT_EN       = 1'b1
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;
  logic          press;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      db_q   <= db;
      // Any sample agreeing with the debounced level restarts the qualification window.
      if (sync_2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = db & ~db_q;

`ifdef AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rpt
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LD  = TW'(REPEAT_CYCLES - 1);

    logic          armed;
    logic [TW-1:0] tmr;
    logic          rpt;

    // Down-counter reloaded at each terminal count; armed only after the initial press pulse.
    always_ff @(posedge clk) begin
      if (!reset_n || !db) begin
        armed <= 1'b0;
        tmr   <= '0;
      end else if (press) begin
        armed <= 1'b1;
        tmr   <= HOLD_LD;
      end else if (armed) begin
        if (tmr == '0) begin
          tmr <= REP_LD;
        end else begin
          tmr <= tmr - TW'(1);
        end
      end
    end

    assign rpt   = db & armed & (tmr == '0);
    assign pulse = press | rpt;
  end else begin : g_norpt
    assign pulse = press;
  end
`else
  assign pulse = press;
`endif

endmodule

module updown_led_counter #(
  parameter int B               = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SATURATE        = 0,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         add_button,
  input  logic         sub_button,
  input  logic         clr_button,
  output logic [B-1:0] LED,
  output logic         at_max,
  output logic         at_min,
  output logic         wrapped
);

  localparam bit PARAMS_OK = (B >= 1) && (B <= 16) && (DEBOUNCE_CYCLES >= 1) &&
                             (SATURATE >= 0) && (SATURATE <= 1) &&
                             (HOLD_CYCLES >= 1) && (REPEAT_CYCLES >= 1);
  localparam bit SAT = (SATURATE != 0);
  localparam logic [B-1:0] LED_MAX = '1;

  if (!PARAMS_OK) begin : g_bad_params
    $error("updown_led_counter: parameter out of range");
  end

  logic add_ev;
  logic sub_ev;
  logic clr_ev;

`ifdef AUTO_REPEAT_EN
  updown_led_counter_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
  ) u_add (.clk(clk), .reset_n(reset_n), .raw(add_button), .pulse(add_ev));

  updown_led_counter_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
  ) u_sub (.clk(clk), .reset_n(reset_n), .raw(sub_button), .pulse(sub_ev));

  updown_led_counter_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)
  ) u_clr (.clk(clk), .reset_n(reset_n), .raw(clr_button), .pulse(clr_ev));
`else
  updown_led_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
    .clk(clk), .reset_n(reset_n), .raw(add_button), .pulse(add_ev)
  );

  updown_led_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
    .clk(clk), .reset_n(reset_n), .raw(sub_button), .pulse(sub_ev)
  );

  updown_led_counter_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .reset_n(reset_n), .raw(clr_button), .pulse(clr_ev)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      LED     <= '0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      // Clear dominates; simultaneous add and sub cancel out.
      if (clr_ev) begin
        LED <= '0;
      end else if (add_ev && !sub_ev) begin
        if (LED == LED_MAX) begin
          if (!SAT) begin
            LED     <= '0;
            wrapped <= 1'b1;
          end
        end else begin
          LED <= LED + B'(1);
        end
      end else if (sub_ev && !add_ev) begin
        if (LED == '0) begin
          if (!SAT) begin
            LED     <= LED_MAX;
            wrapped <= 1'b1;
          end
        end else begin
          LED <= LED - B'(1);
        end
      end
    end
  end

  assign at_max = (LED == LED_MAX);
  assign at_min = (LED == '0);

endmodule

// File: tb/tb_updown_led_counter.sv
// Scoreboard bench: a wrapping and a saturating instance (B=4, DEBOUNCE_CYCLES=4); expected LED
// events are queued at stimulus time and popped by a negedge monitor whenever LED moves or wrapped pulses.

module tb_updown_led_counter;

  localparam int B    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    int       cyc;
    int       led;
    logic     wr;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic add_w = 1'b0, sub_w = 1'b0, clr_w = 1'b0;
  logic add_s = 1'b0, sub_s = 1'b0, clr_s = 1'b0;
  logic [B-1:0] led_w, led_s;
  logic at_max_w, at_min_w, wrapped_w;
  logic at_max_s, at_min_s, wrapped_s;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   model_w = 0;
  int   model_s = 0;
  ev_t  q_w[$];
  ev_t  q_s[$];
  bit   mon_en = 1'b0;
  logic [B-1:0] prev_w = '0, prev_s = '0;

  updown_led_counter #(
    .B(B), .DEBOUNCE_CYCLES(DEB), .SATURATE(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_w (
    .clk(clk), .reset_n(reset_n), .add_button(add_w), .sub_button(sub_w), .clr_button(clr_w),
    .LED(led_w), .at_max(at_max_w), .at_min(at_min_w), .wrapped(wrapped_w)
  );

  updown_led_counter #(
    .B(B), .DEBOUNCE_CYCLES(DEB), .SATURATE(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .add_button(add_s), .sub_button(sub_s), .clr_button(clr_s),
    .LED(led_s), .at_max(at_max_s), .at_min(at_min_s), .wrapped(wrapped_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_check(input int id, input int led, input logic wr, input logic mx, input logic mn);
    ev_t   e;
    string nm;
    nm = (id == 0) ? "wrap_dut_event" : "sat_dut_event";
    checks++;
    if ((id == 0 && q_w.size() == 0) || (id == 1 && q_s.size() == 0)) begin
      errors++;
      $display("FAIL %s: unexpected change cyc=%0d led=%0d wrapped=%0b", nm, cyc, led, wr);
      return;
    end
    if (id == 0) e = q_w.pop_front();
    else e = q_s.pop_front();
    if (cyc != e.cyc || led != e.led || wr != e.wr || mx != (e.led == 15) || mn != (e.led == 0)) begin
      errors++;
      $display("FAIL %s: got cyc=%0d led=%0d wrapped=%0b at_max=%0b at_min=%0b expected cyc=%0d led=%0d wrapped=%0b at_max=%0b at_min=%0b",
               nm, cyc, led, wr, mx, mn, e.cyc, e.led, e.wr, e.led == 15, e.led == 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (led_w != prev_w || wrapped_w) pop_check(0, int'(led_w), wrapped_w, at_max_w, at_min_w);
      if (led_s != prev_s || wrapped_s) pop_check(1, int'(led_s), wrapped_s, at_max_s, at_min_s);
      prev_w <= led_w;
      prev_s <= led_s;
    end
  end

  // mask = {clr, sub, add}; queues the change, if any, that one pulse of this mask produces.
  task automatic apply(input int id, input logic [2:0] mask, input int when);
    int   m, nx;
    bit   sat;
    logic wr;
    ev_t  e;
    m   = (id == 0) ? model_w : model_s;
    sat = (id == 1);
    nx  = m;
    wr  = 1'b0;
    if (mask[2]) nx = 0;
    else if (mask[0] && !mask[1]) begin
      if (m == 15) begin
        if (!sat) begin nx = 0; wr = 1'b1; end
      end else nx = m + 1;
    end else if (mask[1] && !mask[0]) begin
      if (m == 0) begin
        if (!sat) begin nx = 15; wr = 1'b1; end
      end else nx = m - 1;
    end
    if (nx != m || wr) begin
      e.cyc = when;
      e.led = nx;
      e.wr  = wr;
      if (id == 0) q_w.push_back(e);
      else q_s.push_back(e);
    end
    if (id == 0) model_w = nx;
    else model_s = nx;
  endtask

  task automatic set_btn(input int id, input logic [2:0] mask);
    if (id == 0) {clr_w, sub_w, add_w} = mask;
    else {clr_s, sub_s, add_s} = mask;
  endtask

  // Raw level held for n sampling edges; first LED update lands 6 edges after the first sample.
  task automatic press(input int id, input logic [2:0] mask, input int n);
    int c0, e;
    @(posedge clk);
    #1;
    set_btn(id, mask);
    c0 = cyc;
    if (n >= DEB) begin
      apply(id, mask, c0 + 1 + 6);
      if (AR && !mask[2] && (mask[0] ^ mask[1])) begin
        e = 6 + HOLD;
        while (e <= n + 5) begin
          apply(id, mask, c0 + 1 + e);
          e += REP;
        end
      end
    end
    repeat (n) @(posedge clk);
    #1;
    set_btn(id, 3'b000);
    repeat (10) @(posedge clk);
  endtask

  task automatic check_state(input int id, input string nm);
    @(negedge clk);
    if (id == 0) begin
      do_check({nm, "_led"}, int'(led_w), model_w);
      do_check({nm, "_at_max"}, int'(at_max_w), int'(model_w == 15));
      do_check({nm, "_at_min"}, int'(at_min_w), int'(model_w == 0));
    end else begin
      do_check({nm, "_led"}, int'(led_s), model_s);
      do_check({nm, "_at_max"}, int'(at_max_s), int'(model_s == 15));
      do_check({nm, "_at_min"}, int'(at_min_s), int'(model_s == 0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    add_w = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_check("reset_led_w", int'(led_w), 0);
    do_check("reset_at_min_w", int'(at_min_w), 1);
    do_check("reset_at_max_w", int'(at_max_w), 0);
    do_check("reset_wrapped_w", int'(wrapped_w), 0);
    do_check("reset_led_s", int'(led_s), 0);
    do_check("reset_at_min_s", int'(at_min_s), 1);
    prev_w = '0;
    prev_s = '0;
    mon_en = 1'b1;

    // add held through reset: counts as one fresh press measured from reset release
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    c0 = cyc;
    apply(0, 3'b001, c0 + 7);
    repeat (6) @(posedge clk);
    #1;
    add_w = 1'b0;
    repeat (10) @(posedge clk);
    check_state(0, "held_reset");

    press(0, 3'b001, 3);
    check_state(0, "glitch");
    press(0, 3'b001, 10);
    check_state(0, "clean_hold");
    press(0, 3'b100, 6);
    check_state(0, "clear");
    repeat (16) press(0, 3'b001, 6);
    check_state(0, "wrap16");
    press(0, 3'b010, 6);
    check_state(0, "sub_wrap");
    press(0, 3'b011, 6);
    check_state(0, "add_sub_cancel");
    repeat (10) press(0, 3'b001, 6);
    check_state(0, "nine");
    press(0, 3'b101, 6);
    check_state(0, "clr_add");
    press(0, 3'b001, 25);
    check_state(0, "hold25");

    press(1, 3'b010, 6);
    check_state(1, "sat_sub_at0");
    repeat (20) press(1, 3'b001, 6);
    check_state(1, "sat_top");
    press(1, 3'b001, 6);
    check_state(1, "sat_hold_top");
    press(1, 3'b010, 6);
    check_state(1, "sat_down");

    repeat (4) @(posedge clk);
    @(negedge clk);
    do_check("queue_w_drained", q_w.size(), 0);
    do_check("queue_s_drained", q_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
